// File: rtl/axi_lite_pkg.sv
// Shared types and default widths for the AXI4-Lite master.
// Response codes and master FSM state encoding.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_RSP
    } axi_mst_state_e;

endpackage

// File: rtl/axi_lite_stat_cnt.sv
// 16-bit saturating event counter.
// Used for the optional transaction statistics.
module axi_lite_stat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    // count events, sticking at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master with a command/response port.
// Optional stats counters: define AXI_LITE_MASTER_STATS_EN.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] aw_addr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] w_data,
    output logic [DATA_W/8-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
`ifdef AXI_LITE_MASTER_STATS_EN
    ,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_err_cnt
`endif
);

    axi_mst_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic aw_done_q, w_done_q;
    logic cmd_fire;

    assign cmd_fire = (state_q == S_IDLE) && cmd_valid;
    assign aw_addr  = addr_q;
    assign ar_addr  = addr_q;
    assign w_data   = wdata_q;
    assign wstrb    = '1;

    // state register; reset aborts any exchange in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake outputs, decoded from registers only
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = rst;
                if (cmd_valid) begin
                    state_d = cmd_write ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_d = S_RSP;
            end
            S_WR_REQ: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // command capture, per-channel done flags and response capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                rsp_write <= cmd_write;
                rsp_rdata <= '0;
                rsp_resp  <= '0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == S_WR_REQ) begin
                if (awready) aw_done_q <= 1'b1;
                if (wready)  w_done_q  <= 1'b1;
            end
            if (state_q == S_RD_DATA && rvalid) begin
                rsp_rdata <= r_data;
                rsp_resp  <= rresp;
            end
            if (state_q == S_WR_RESP && bvalid) begin
                rsp_resp <= bresp;
            end
        end
    end

`ifdef AXI_LITE_MASTER_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready;

    axi_lite_stat_cnt u_rd_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rsp_fire && !rsp_write),
        .cnt (stat_rd_cnt)
    );

    axi_lite_stat_cnt u_wr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rsp_fire && rsp_write),
        .cnt (stat_wr_cnt)
    );

    axi_lite_stat_cnt u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rsp_fire && rsp_resp[1]),
        .cnt (stat_err_cnt)
    );
`endif

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator: the master end of the read/write channel set already served by the axi slave.
- Accepts one read or write command on a simple valid/ready command port, runs the full AW/W/B or AR/R exchange, and returns data and response on a held response port.
- Replaces hand-driven bench stimulus and serves as the bus master for the register path in integration.

Parameters:
- ADDR_W, 32, address width of cmd_addr, aw_addr, ar_addr.
- DATA_W, 32, data width (32 or 64); wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master idle; command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transaction address.
- cmd_wdata  in  DATA_W  write data, ignored for reads.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_write  out  1  result belongs to a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  rresp or bresp copied from the slave.
- aw_addr / awvalid / awready  out / out / in  ADDR_W / 1 / 1  write address channel.
- w_data / wstrb / wvalid / wready  out / out / out / in  DATA_W / DATA_W/8 / 1 / 1  write data channel.
- bresp / bvalid / bready  in / in / out  2 / 1 / 1  write response channel.
- ar_addr / arvalid / arready  out / out / in  ADDR_W / 1 / 1  read address channel.
- r_data / rresp / rvalid / rready  in / in / in / out  DATA_W / 2 / 1 / 1  read data channel.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All valid and ready outputs go to 0, except that cmd_ready follows IDLE and reads 1 after reset release.
  - aw_addr, ar_addr, w_data, rsp_rdata, rsp_resp and rsp_write reset to 0.
- Reset mid-transaction aborts immediately, with no wait for the slave.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On command handshake in cycle T, register addr and data; go to RD_ADDR or WR_REQ.
  - arvalid or awvalid+wvalid is high at T+1.
- RD_ADDR:
  - arvalid = 1, ar_addr stable.
  - On arready: drop arvalid, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture r_data and rresp, go to RSP.
  - rvalid is ignored in any other state.
- WR_REQ:
  - awvalid and wvalid are both asserted at entry.
  - Each valid drops independently on its own ready (done flags aw_done, w_done).
  - Same-cycle awready and wready completes both.
  - Leave for WR_RESP once both are done; data and address are held stable until their own handshake.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp, go to RSP.
  - bvalid before WR_RESP is ignored.
- RSP:
  - rsp_valid = 1, payload stable until rsp_ready; then IDLE.
  - cmd_ready = 0 outside IDLE, so there is no back-to-back issue.
- Minimum latency with a zero-wait slave: read 3 cycles from cmd handshake to rsp_valid; write 3 cycles.
- wstrb is constant all-ones.
- rsp_resp passes the slave value unmodified: 00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR.
- All AXI outputs are registered; there is no combinational path from any slave input to any AXI output.

Optional Feature:
- Macro AXI_LITE_MASTER_STATS_EN.
- When defined, three 16-bit saturating counters are added as outputs:
  - stat_rd_cnt: completed reads.
  - stat_wr_cnt: completed writes.
  - stat_err_cnt: responses with resp[1] = 1.
- Counters increment on the RSP→IDLE handshake, reset to 0 and hold at 16'hFFFF.
- When undefined, the ports and logic are absent and the block is otherwise identical.

Decomposition:
- axi_lite_pkg:
  - Enum axi_resp_e (OKAY, EXOKAY, SLVERR, DECERR).
  - Enum axi_mst_state_e.
  - Default ADDR_W/DATA_W constants.
- The optional counters form a natural sub-module, axi_lite_stat_cnt, instantiated three times under the macro.
- The rest stays flat.

Test Plan:
- Reset: hold rst = 0 for 3 cycles → all valids 0, rsp_* 0; after release cmd_ready = 1.
- Read, zero-wait slave: cmd read addr 32'hABCDEF10, slave returns 32'hCAFEF00D / rresp 00 → ar_addr = 32'hABCDEF10 at T+1, rsp_valid at T+3 with rsp_rdata = 32'hCAFEF00D, rsp_resp = 00, rsp_write = 0.
- Write, skewed readies: cmd write addr 32'hFFFFFFFF data 32'h12345678; wready at T+1, awready delayed to T+4 → wvalid drops after T+1, awvalid held through T+4, bready only after T+4, rsp after bvalid.
- Error propagation: slave bresp = 2'b10 → rsp_resp = 2'b10 (stat_err_cnt = 1 with macro).
- Backpressure: rsp_ready low for 5 cycles → rsp_valid and payload stable, cmd_ready = 0, new cmd_valid not accepted.
- Reset mid-write: assert rst = 0 while awvalid = 1 → awvalid and wvalid fall immediately; next command runs normally.
